huffman_decoder: RTL and testbench

//  Sink for the Huffman encoder's code-table interface and compressed bitstream.
//  - Loads the symbol/length/codeword table, one entry per cycle, while tbl_valid is high.
//  - Then consumes the compressed bitstream serially, MSB of each codeword first.
//  - Emits one decoded symbol per matched codeword, over a valid/ready handshake.
//  - Sits at the decompression end of the encode/decode data path.

---
 rtl/huffman_decoder.sv | 174 +++++++++++++++++
 tb/tb_huffman_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decoder.sv
// Huffman decoder: loads a symbol/length/codeword table, then decodes a
// serial MSB-first bitstream into symbols over a valid/ready handshake.
// The table is scanned one entry per cycle; the lowest matching index wins.
module huffman_decoder #(
    parameter int bit_width  = 7,
    parameter int max_symbol = 255
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   tbl_valid,
    input  logic [bit_width:0]     tbl_symbol,
    input  logic [3:0]             tbl_length,
    input  logic [2*bit_width+2:0] tbl_code,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic [bit_width:0]     sym_out,
    output logic                   sym_valid,
    input  logic                   sym_ready,
    output logic [8:0]             table_count,
    output logic                   err,
    output logic [2:0]             out_state
);

    localparam int depth  = max_symbol + 1;
    localparam int idx_w  = (depth > 1) ? $clog2(depth) : 1;
    localparam int code_w = 2 * bit_width + 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        SEARCH = 3'd3,
        EMIT   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t state;

    // Code table storage
    logic [bit_width:0] sym_mem  [depth];
    logic [3:0]         len_mem  [depth];
    logic [code_w-1:0]  code_mem [depth];

    // Bit accumulator and scan pointer
    logic [code_w-1:0] acc;
    logic [3:0]        acc_len;
    logic [idx_w-1:0]  idx;

    logic              table_we;
    logic [code_w-1:0] len_mask;
    logic              entry_hit;
    logic              last_entry;

    // A new entry is stored only while the table still has room; the first
    // entry lands at index 0 because table_count is 0 in IDLE.
    assign table_we = tbl_valid &&
                      ((state == IDLE) ||
                       ((state == LOAD) && (table_count < 9'(depth))));

    // Mask covering the acc_len low bits of a codeword.
    assign len_mask = ~({code_w{1'b1}} << acc_len);

    // Zero-length entries never match because acc_len is at least 1 in SEARCH
    // and the explicit non-zero test keeps that true regardless.
    assign entry_hit = (len_mem[idx] != 4'd0) &&
                       (len_mem[idx] == acc_len) &&
                       (((code_mem[idx] ^ acc) & len_mask) == '0);

    assign last_entry = (9'(idx) == (table_count - 9'd1));

    assign out_state = state;

    // Table write port
    // NOTE: the table RAM has no reset; clearing table_count is what
    // invalidates it, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clock) begin
        if (table_we) begin
            sym_mem[table_count[idx_w-1:0]]  <= tbl_symbol;
            len_mem[table_count[idx_w-1:0]]  <= tbl_length;
            code_mem[table_count[idx_w-1:0]] <= tbl_code;
        end
    end

    // Control FSM with registered handshake outputs
    // NOTE: every register here uses <= so all updates take effect together
    // at the edge and the order of statements does not matter.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            table_count <= 9'd0;
            err         <= 1'b0;
            bit_ready   <= 1'b0;
            sym_valid   <= 1'b0;
            sym_out     <= '0;
            acc         <= '0;
            acc_len     <= 4'd0;
            idx         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tbl_valid) begin
                        table_count <= 9'd1;
                        state       <= LOAD;
                    end
                end

                LOAD: begin
                    if (tbl_valid) begin
                        if (table_count < 9'(depth)) begin
                            table_count <= table_count + 9'd1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        acc       <= '0;
                        acc_len   <= 4'd0;
                        bit_ready <= 1'b1;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (bit_valid && bit_ready) begin
                        acc       <= {acc[code_w-2:0], bit_in};
                        acc_len   <= acc_len + 4'd1;
                        idx       <= '0;
                        bit_ready <= 1'b0;
                        state     <= SEARCH;
                    end
                end

                SEARCH: begin
                    if (entry_hit) begin
                        sym_out   <= sym_mem[idx];
                        sym_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (last_entry) begin
                        if (acc_len == 4'd15) begin
                            err   <= 1'b1;
                            state <= ERROR;
                        end else begin
                            bit_ready <= 1'b1;
                            state     <= SHIFT;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                EMIT: begin
                    if (sym_ready) begin
                        sym_valid <= 1'b0;
                        acc       <= '0;
                        acc_len   <= 4'd0;
                        bit_ready <= 1'b1;
                        state     <= SHIFT;
                    end
                end

                ERROR: begin
                    err       <= 1'b1;
                    bit_ready <= 1'b0;
                    sym_valid <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed testbench for huffman_decoder: basic decode, backpressure,
// invalid code, search latency, table overflow and mid-search reset.
module tb_huffman_decoder;

    logic        clock;
    logic        rst;
    logic        tbl_valid;
    logic [7:0]  tbl_symbol;
    logic [3:0]  tbl_length;
    logic [16:0] tbl_code;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [7:0]  sym_out;
    logic        sym_valid;
    logic        sym_ready;
    logic [8:0]  table_count;
    logic        err;
    logic [2:0]  out_state;

    int checks = 0;
    int errors = 0;

    huffman_decoder #(.bit_width(7), .max_symbol(255)) dut (
        .clock       (clock),
        .rst         (rst),
        .tbl_valid   (tbl_valid),
        .tbl_symbol  (tbl_symbol),
        .tbl_length  (tbl_length),
        .tbl_code    (tbl_code),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .sym_out     (sym_out),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .table_count (table_count),
        .err         (err),
        .out_state   (out_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_bit_ready"},   32'(bit_ready),   32'd0);
        check({tag, "_sym_out"},     32'(sym_out),     32'd0);
        check({tag, "_sym_valid"},   32'(sym_valid),   32'd0);
        check({tag, "_table_count"}, 32'(table_count), 32'd0);
        check({tag, "_err"},         32'(err),         32'd0);
        check({tag, "_state"},       32'(out_state),   32'd0);
    endtask

    task automatic apply_reset(input string tag);
        tbl_valid = 1'b0;
        bit_valid = 1'b0;
        sym_ready = 1'b1;
        rst       = 1'b1;
        #1;
        check_cleared(tag);
        tick();
        rst = 1'b0;
    endtask

    task automatic load_entry(input logic [7:0] sym, input logic [3:0] len,
                              input logic [16:0] code);
        tbl_symbol = sym;
        tbl_length = len;
        tbl_code   = code;
        tbl_valid  = 1'b1;
        tick();
        tbl_valid  = 1'b0;
    endtask

    task automatic end_load();
        tbl_valid = 1'b0;
        tick();
    endtask

    task automatic send_bit(input logic b);
        int n = 0;
        while (!bit_ready && n < 4000) begin
            tick();
            n++;
        end
        check("bit_ready_wait", 32'(bit_ready), 32'd1);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_code(input logic [16:0] code, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            send_bit(code[i]);
        end
    endtask

    task automatic expect_sym(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!sym_valid && n < 4000) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(sym_valid), 32'd1);
        check(tag, 32'(sym_out), 32'(exp));
        tick();
    endtask

    task automatic load_t1();
        load_entry("a", 4'd1, 17'b0);
        load_entry("b", 4'd2, 17'b10);
        load_entry("c", 4'd2, 17'b11);
        end_load();
    endtask

    // Stream 0,1,0,1,1 and expect a, b, c
    task automatic stream_t1(input string tag);
        send_code(17'b0, 1);
        expect_sym({tag, "_a"}, "a");
        send_code(17'b10, 2);
        expect_sym({tag, "_b"}, "b");
        send_code(17'b11, 2);
        expect_sym({tag, "_c"}, "c");
        check({tag, "_count"}, 32'(table_count), 32'd3);
        check({tag, "_err"},   32'(err),         32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        tbl_valid  = 1'b0;
        tbl_symbol = '0;
        tbl_length = '0;
        tbl_code   = '0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        sym_ready  = 1'b1;

        // Reset state
        apply_reset("reset");

        // T1 basic decode
        load_t1();
        check("t1_state_shift", 32'(out_state), 32'd2);
        stream_t1("t1");

        // T2 backpressure: 'a' held while sym_ready is low
        apply_reset("t2_reset");
        load_t1();
        sym_ready = 1'b0;
        send_bit(1'b0);
        begin
            int n = 0;
            while (!sym_valid && n < 100) begin
                tick();
                n++;
            end
        end
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(sym_valid), 32'd1);
            check("t2_hold_sym",   32'(sym_out),   32'("a"));
            check("t2_hold_ready", 32'(bit_ready), 32'd0);
            check("t2_hold_state", 32'(out_state), 32'd4);
            tick();
        end
        sym_ready = 1'b1;
        tick();
        bit_valid = 1'b0;
        check("t2_after_valid", 32'(sym_valid), 32'd0);
        send_code(17'b10, 2);
        expect_sym("t2_b", "b");
        send_code(17'b11, 2);
        expect_sym("t2_c", "c");

        // T3 invalid code: fifteen ones never match
        apply_reset("t3_reset");
        load_entry("x", 4'd2, 17'b00);
        load_entry("y", 4'd2, 17'b01);
        end_load();
        for (int i = 0; i < 14; i++) begin
            send_bit(1'b1);
        end
        check("t3_err_before", 32'(err), 32'd0);
        send_bit(1'b1);
        begin
            int n = 0;
            while (out_state != 3'd5 && n < 10) begin
                tick();
                n++;
            end
        end
        check("t3_state",     32'(out_state), 32'd5);
        check("t3_err",       32'(err),       32'd1);
        check("t3_bit_ready", 32'(bit_ready), 32'd0);
        check("t3_sym_valid", 32'(sym_valid), 32'd0);
        tick();
        tick();
        check("t3_state_stuck", 32'(out_state), 32'd5);

        // T4 latency: codeword matches index 2, sym_valid 3 edges later
        apply_reset("t4_reset");
        load_entry("p", 4'd2, 17'b00);
        load_entry("q", 4'd2, 17'b01);
        load_entry("r", 4'd1, 17'b1);
        end_load();
        send_bit(1'b1);
        check("t4_edge0", 32'(sym_valid), 32'd0);
        tick();
        check("t4_edge1", 32'(sym_valid), 32'd0);
        tick();
        check("t4_edge2", 32'(sym_valid), 32'd0);
        tick();
        check("t4_edge3", 32'(sym_valid), 32'd1);
        check("t4_sym",   32'(sym_out),   32'("r"));
        tick();
        check("t4_count", 32'(table_count), 32'd3);

        // T5 overflow: 257 entries, the last one must be discarded
        apply_reset("t5_reset");
        for (int i = 0; i < 256; i++) begin
            load_entry(i[7:0], 4'd8, 17'(i));
        end
        load_entry(8'h5a, 4'd8, 17'd0);
        end_load();
        check("t5_count", 32'(table_count), 32'd256);
        check("t5_err",   32'(err),         32'd1);
        send_code(17'd0, 8);
        expect_sym("t5_sym0", 8'd0);
        send_code(17'd1, 8);
        expect_sym("t5_sym1", 8'd1);
        send_code(17'd127, 8);
        expect_sym("t5_sym127", 8'd127);
        send_code(17'd200, 8);
        expect_sym("t5_sym200", 8'd200);
        send_code(17'd255, 8);
        expect_sym("t5_sym255", 8'd255);
        check("t5_err_sticky", 32'(err), 32'd1);

        // T6 reset asserted during SEARCH clears outputs asynchronously
        apply_reset("t6_reset");
        load_t1();
        send_bit(1'b0);
        check("t6_in_search", 32'(out_state), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("t6_async");
        tick();
        rst = 1'b0;
        load_t1();
        stream_t1("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
